// File: rtl/alu_chain_pkg.sv
// rtl/alu_chain_pkg.sv - shared types and constants for the multi-byte add/sub sequencer
package alu_chain_pkg;

  localparam int IDX_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRIVE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_chain_ctl_if.sv
// rtl/alu_chain_ctl_if.sv - command, datapath and flag signals of the sequencer
// Optional overflow signals exist only when ALU_CHAIN_OVF_EN is defined.
interface alu_chain_ctl_if
  import alu_chain_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) ();

  logic             start;
  logic             op_sub;
  logic [IDX_W:0]   len;
  logic             alu_cout;
  logic [7:0]       alu_res;
  logic [IDX_W-1:0] byte_idx;
  logic             alu_sub;
  logic             alu_cin;
  logic             alu_outn;
  logic             res_we;
  logic             busy;
  logic             done;
  logic             flag_c;
  logic             flag_z;
`ifdef ALU_CHAIN_OVF_EN
  logic             sign_l;
  logic             sign_r;
  logic             flag_v;
`endif

  // slave: the sequencer itself
  modport slave (
`ifdef ALU_CHAIN_OVF_EN
    input  sign_l, sign_r,
    output flag_v,
`endif
    input  start, op_sub, len, alu_cout, alu_res,
    output byte_idx, alu_sub, alu_cin, alu_outn, res_we, busy, done, flag_c, flag_z
  );

  // master: control-word decoder plus byte-lane datapath
  modport master (
`ifdef ALU_CHAIN_OVF_EN
    output sign_l, sign_r,
    input  flag_v,
`endif
    output start, op_sub, len, alu_cout, alu_res,
    input  byte_idx, alu_sub, alu_cin, alu_outn, res_we, busy, done, flag_c, flag_z
  );

endinterface

// File: rtl/alu_chain_flags.sv
// rtl/alu_chain_flags.sv - inter-byte carry, zero/overflow accumulation and final flag registers
// Overflow tracking is present only when ALU_CHAIN_OVF_EN is defined.
module alu_chain_flags (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       drive_i,
  input  logic       fin_i,
  input  logic       alu_cout_i,
  input  logic [7:0] alu_res_i,
`ifdef ALU_CHAIN_OVF_EN
  input  logic       op_i,
  input  logic       sign_l_i,
  input  logic       sign_r_i,
  output logic       flag_v_o,
`endif
  output logic       carry_o,
  output logic       flag_c_o,
  output logic       flag_z_o
);

  logic carry_q;
  logic zacc_q;
  logic flag_c_q;
  logic flag_z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (clear_i) begin
        zacc_q <= 1'b1;
      end
      if (drive_i) begin
        carry_q <= alu_cout_i;
        zacc_q  <= zacc_q & (alu_res_i == 8'h00);
      end
      if (fin_i) begin
        flag_c_q <= carry_q;
        flag_z_q <= zacc_q;
      end
    end
  end

`ifdef ALU_CHAIN_OVF_EN
  logic v_q;
  logic flag_v_q;

  // signed overflow of the byte just driven; only the last byte's value survives to FIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q      <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      if (drive_i) begin
        v_q <= (sign_l_i == (sign_r_i ^ op_i)) & (alu_res_i[7] != sign_l_i);
      end
      if (fin_i) begin
        flag_v_q <= v_q;
      end
    end
  end

  assign flag_v_o = flag_v_q;
`endif

  assign carry_o  = carry_q;
  assign flag_c_o = flag_c_q;
  assign flag_z_o = flag_z_q;

endmodule

// File: rtl/alu_chain_ctl.sv
// rtl/alu_chain_ctl.sv - sequencer driving an 8-bit add/sub datapath for LSB-first multi-byte ADD/SUB
// Define ALU_CHAIN_OVF_EN to add sign_l/sign_r inputs and the flag_v output.
module alu_chain_ctl
  import alu_chain_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  alu_chain_ctl_if.slave bus
);

  localparam logic [IDX_W:0] MAX_LEN = {1'b1, {IDX_W{1'b0}}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_q, op_d;
  logic [IDX_W:0]   len_q, len_d;
  logic             accept;
  logic [IDX_W-1:0] last_idx;
  logic             carry;
  logic             busy;

  assign last_idx = IDX_W'(len_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    len_d   = len_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          op_d   = bus.op_sub;
          idx_d  = '0;
          if (bus.len == '0) begin
            len_d   = '0;
            state_d = ST_FIN;
          end else begin
            len_d   = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_DRIVE;
      ST_DRIVE: begin
        if (idx_q == last_idx) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SETUP;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs decode straight from registered state so an async reset releases the bus at once
  assign busy         = (state_q != ST_IDLE);
  assign bus.busy     = busy;
  assign bus.done     = (state_q == ST_FIN);
  assign bus.res_we   = (state_q == ST_DRIVE);
  assign bus.alu_outn = (state_q != ST_DRIVE);
  assign bus.byte_idx = idx_q;
  assign bus.alu_sub  = busy & op_q;
  assign bus.alu_cin  = busy & ((idx_q == '0) ? op_q : carry);

  alu_chain_flags u_flags (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .drive_i    (state_q == ST_DRIVE),
    .fin_i      ((state_q == ST_FIN) && (len_q != '0)),
    .alu_cout_i (bus.alu_cout),
    .alu_res_i  (bus.alu_res),
`ifdef ALU_CHAIN_OVF_EN
    .op_i       (op_q),
    .sign_l_i   (bus.sign_l),
    .sign_r_i   (bus.sign_r),
    .flag_v_o   (bus.flag_v),
`endif
    .carry_o    (carry),
    .flag_c_o   (bus.flag_c),
    .flag_z_o   (bus.flag_z)
  );

endmodule

// File: tb/tb_alu_chain_ctl.sv
// tb/tb_alu_chain_ctl.sv - directed and random checks of alu_chain_ctl against a multi-byte arithmetic model
module tb_alu_chain_ctl;
  import alu_chain_pkg::*;

  localparam int IW = 2;
  localparam int MAXB = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_chain_ctl_if #(.IDX_W(IW)) bus ();
  alu_chain_ctl #(.IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] a_op = '0;
  logic [31:0] b_op = '0;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [7:0] q_res[$];
  int         q_idx[$];
  logic       q_cin[$];
  logic exp_c = 1'b0, exp_z = 1'b0, exp_v = 1'b0;

  // byte-lane datapath: selected operand bytes, optional invert, 8-bit add with carry
  always_comb begin : datapath
    logic [7:0] bl, br;
    logic [8:0] s;
    bl = a_op[int'(bus.byte_idx)*8 +: 8];
    br = b_op[int'(bus.byte_idx)*8 +: 8];
    s  = {1'b0, bl} + {1'b0, (bus.alu_sub ? ~br : br)} + {8'b0, bus.alu_cin};
    bus.alu_res  = s[7:0];
    bus.alu_cout = s[8];
`ifdef ALU_CHAIN_OVF_EN
    bus.sign_l = bl[7];
    bus.sign_r = br[7];
`endif
  end

  always @(negedge clk) begin
    if (bus.res_we) begin
      q_res.push_back(bus.alu_res);
      q_idx.push_back(int'(bus.byte_idx));
      q_cin.push_back(bus.alu_cin);
    end
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic op, input int len_in, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int n, cycles, exp_cyc;
    logic [63:0] am, bm, r, mk;
    n  = (len_in > MAXB) ? MAXB : len_in;
    mk = (64'd1 << (8 * n)) - 1;
    am = {32'b0, a} & mk;
    bm = {32'b0, b} & mk;
    r  = op ? (am - bm) : (am + bm);
    exp_cyc = (n == 0) ? 1 : 2 * n + 1;
    a_op = a;
    b_op = b;
    @(negedge clk);
    q_res.delete(); q_idx.delete(); q_cin.delete();
    done_cnt = 0;
    bus.start  = 1'b1;
    bus.op_sub = op;
    bus.len    = (IW+1)'(len_in);
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 1;
    while (!bus.done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      bus.start = poke && (cycles == 2);
      if (poke) bus.op_sub = ~op;
    end
    bus.start = 1'b0;
    chk("latency", cycles, exp_cyc);
    @(negedge clk);
    if (n > 0) begin
      exp_c = op ? (am >= bm) : ((am + bm) >> (8 * n)) != 0;
      exp_z = (r & mk) == 0;
      exp_v = op ? ((am[8*n-1] != bm[8*n-1]) && (r[8*n-1] != am[8*n-1]))
                 : ((am[8*n-1] == bm[8*n-1]) && (r[8*n-1] != am[8*n-1]));
    end
    chk("busy_after", bus.busy, 0);
    chk("we_count", q_res.size(), n);
    for (int k = 0; k < n && k < q_res.size(); k++) begin
      logic [63:0] km;
      logic ecin;
      km = (64'd1 << (8 * k)) - 1;
      if (k == 0) ecin = op;
      else ecin = op ? ((am & km) >= (bm & km)) : (((am & km) + (bm & km)) >> (8 * k)) != 0;
      chk("byte_idx", q_idx[k], k);
      chk("result", q_res[k], r[8*k +: 8]);
      chk("cin", q_cin[k], ecin);
    end
    chk("flag_c", bus.flag_c, exp_c);
    chk("flag_z", bus.flag_z, exp_z);
`ifdef ALU_CHAIN_OVF_EN
    chk("flag_v", bus.flag_v, exp_v);
`endif
    if (poke) begin
      repeat (8) @(negedge clk);
      chk("single_done", done_cnt, 1);
      chk("busy_idle", bus.busy, 0);
    end
  endtask

  initial begin
    int w;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.len    = '0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_outn", bus.alu_outn, 1);
    chk("rst_we", bus.res_we, 0);
    chk("rst_idx", bus.byte_idx, 0);
    chk("rst_sub", bus.alu_sub, 0);
    chk("rst_cin", bus.alu_cin, 0);
    chk("rst_fc", bus.flag_c, 0);
    chk("rst_fz", bus.flag_z, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 2, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op(1'b1, 2, 32'h0000_0100, 32'h0000_0001, 1'b0);
    run_op(1'b1, 4, 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op(1'b0, 0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    run_op(1'b0, 3, 32'h00FF_FFFF, 32'h0000_0001, 1'b1);
    run_op(1'b0, 7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
`ifdef ALU_CHAIN_OVF_EN
    run_op(1'b0, 1, 32'h0000_007F, 32'h0000_0001, 1'b0);
    chk("ovf_add_v", bus.flag_v, 1);
    chk("ovf_add_c", bus.flag_c, 0);
    run_op(1'b1, 1, 32'h0000_0080, 32'h0000_0001, 1'b0);
    chk("ovf_sub_v", bus.flag_v, 1);
    chk("ovf_sub_c", bus.flag_c, 1);
`endif

    // async reset while byte 1 is on the bus
    a_op = 32'h0000_1234;
    b_op = 32'h0000_0101;
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.len = 3'd2;
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (!(bus.res_we && bus.byte_idx == 1) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("reach_drive1", w < 20, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_outn", bus.alu_outn, 1);
    chk("arst_we", bus.res_we, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_fc", bus.flag_c, 0);
    chk("arst_fz", bus.flag_z, 0);
    exp_c = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 2, 32'h0000_0100, 32'h0000_0001, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_chain_ctl.md
Name: alu_chain_ctl

Overview:
- Sequencer that drives the 8-bit add/sub datapath one byte at a time to perform multi-byte ADD/SUB (up to MAX_BYTES bytes, LSB first).
- Selects operand byte index, drives the datapath's sub, carry-in and active-low output-enable, latches inter-byte carry, pulses result write-enable, and produces final C/Z flags.
- Sits between the microcode control word decoder and the ALU/register-file byte lanes.

Parameters:
- IDX_W, 2, byte-index width; MAX_BYTES = 2**IDX_W (default 4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- op_sub  in  1  0 = ADD, 1 = SUB; captured on accepted start
- len  in  IDX_W+1  byte count, 0..MAX_BYTES; captured on accepted start
- alu_cout  in  1  carry-out of the datapath's high nibble for the current byte
- alu_res  in  8  datapath result byte (bus value while alu_outn = 0)
- byte_idx  out  IDX_W  operand/result byte index currently being processed
- alu_sub  out  1  to datapath sub input (operand invert)
- alu_cin  out  1  to datapath low-nibble carry-in
- alu_outn  out  1  datapath bus-buffer enable, active-low
- res_we  out  1  result-byte write strobe (one cycle per byte)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at completion
- flag_c  out  1  final carry (SUB: 1 = no borrow)
- flag_z  out  1  1 if every result byte was 0x00

Behaviour:
- Reset (async, active-high): state = IDLE; byte_idx = 0, alu_sub = 0, alu_cin = 0, alu_outn = 1, res_we = 0, busy = 0, done = 0, flag_c = 0, flag_z = 0; latched op/len/carry cleared. Reset mid-operation aborts immediately; no further res_we.
- States: IDLE, SETUP, DRIVE, FIN.
- IDLE: start = 1 captures op_sub, len; byte_idx <= 0; zacc <= 1. If len = 0, go to FIN, leaving flags unchanged. If len > MAX_BYTES, clamp to MAX_BYTES. Otherwise go to SETUP.
- SETUP: alu_outn = 1. byte_idx is stable for datapath operand settling.
- DRIVE: alu_outn = 0, res_we = 1 (single cycle).
  - At the clock edge ending DRIVE: carry_reg <= alu_cout; zacc <= zacc & (alu_res == 0).
  - If byte_idx == len-1, go to FIN; else byte_idx <= byte_idx+1 and go to SETUP.
- FIN: done = 1 for one cycle. flag_c <= carry_reg and flag_z <= zacc (skipped if len = 0). Return to IDLE.
- alu_sub = latched op for the whole operation; 0 in IDLE.
- alu_cin: byte 0 = latched op (two's-complement +1 on SUB); bytes 1.. = carry_reg.
- Latency: len = n gives 2n+1 cycles from the start edge to the done pulse. len = 0 gives 1 cycle.
- start while busy is ignored (no queueing). Flags hold until the next completed operation.
- byte_idx never wraps: the final index is len-1 ≤ MAX_BYTES-1.

Optional Feature:
- Macro ALU_CHAIN_OVF_EN.
- Defined:
  - Adds inputs sign_l, sign_r (1 bit, MSB of left/right operand for the current byte) and output flag_v.
  - In DRIVE, track v = (sign_l == (sign_r ^ op)) & (alu_res[7] != sign_l).
  - flag_v <= v of the last byte in FIN. flag_v resets to 0; unchanged for len = 0.
- Undefined: these ports and logic are absent.

Decomposition:
- Package alu_chain_pkg: state enum (IDLE, SETUP, DRIVE, FIN), IDX_W default constant.
- Optional sub-module alu_chain_flags: carry/zero/overflow accumulation and FIN-time flag update.
- Next-state/output logic stays in alu_chain_ctl.

Test Plan:
- ADD, len = 2, bytes 0x00FF + 0x0001 (model the datapath) → res_we at idx 0 then 1; alu_cin = 0 then 1; results 0x00, 0x01; flag_c = 0, flag_z = 0; done 5 cycles after start.
- SUB, len = 2, 0x0100 − 0x0001 → byte 0 cin = 1, result 0xFF, carry 0; byte 1 cin = 0, result 0x00; flag_c = 1; flag_z = 0.
- SUB, len = 4, 0x12345678 − 0x12345678 → all bytes 0x00, flag_z = 1, flag_c = 1; exactly 4 res_we pulses.
- len = 0 start → done pulse next cycle, no res_we, flags unchanged from previous op. Also: start asserted while busy → ignored, exactly one done.
- Assert rst during DRIVE of byte 1 → alu_outn = 1, res_we = 0, busy = 0 asynchronously; a new start after reset runs normally.
- ALU_CHAIN_OVF_EN, len = 1 ADD 0x7F + 0x01 → flag_v = 1, flag_c = 0. Then 0x80 − 0x01 → flag_v = 1, flag_c = 1.
